ctx_mem_responder: RTL and testbench
====================================

# ctx_mem_responder

Simulation-side responder for the RTOS-unit context-memory port. It sits opposite the core/RTOS-unit wrapper and owns a word-addressed context store. It commits writes presented on the write channel. Every read request is answered with a data beat after a fixed, parameterised latency, because the initiator has no backpressure and may issue a request on every cycle. It also counts protocol anomalies so the bench can check them.

## Interface
Parameters:
- `MEM_WORDS`, 1024: depth of the store in 32-bit words; must be a power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `RD_LATENCY`, 2: cycles from an accepted read request to its response; legal range 1..8.
- `ERR_DATA`, 32'hDEAD_BEEF: data returned for out-of-range reads.

Ports:
- `clk_i`  in  1  clock; all logic is rising-edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `ctx_mem_wr_en_i`  in  1  write strobe, one word per cycle.
- `ctx_mem_wr_addr_i`  in  32  write byte address.
- `ctx_mem_wr_data_i`  in  32  write data.
- `ctx_mem_rd_rq_valid_i`  in  1  read request strobe; always accepted.
- `ctx_mem_rd_rq_addr_i`  in  32  read byte address.
- `ctx_mem_rd_resp_valid_o`  out  1  response beat valid.
- `ctx_mem_rd_data_o`  out  32  response data.
- `outstanding_o`  out  4  number of reads in flight.
- `oob_cnt_o`  out  16  count of out-of-range accesses, saturating.
- `misalign_cnt_o`  out  16  count of accesses with addr[1:0]≠0, saturating.
- `collide_cnt_o`  out  16  count of cycles with a write and a read both asserted, saturating.

## Operation
- Word index: idx = (addr − BASE_ADDR) >> 2. The subtraction is 32-bit unsigned.
  - An access is in range iff (addr − BASE_ADDR) < MEM_WORDS*4.
  - addr[1:0] is ignored for indexing (the access is aligned down). A nonzero addr[1:0] increments `misalign_cnt_o`.
- Write:
  - In range: on `ctx_mem_wr_en_i`, mem[idx] ← wr_data at the clock edge.
  - Out of range: the write is dropped and `oob_cnt_o` increments.
- Read:
  - On `ctx_mem_rd_rq_valid_i`, the store is sampled in that cycle and the value enters a RD_LATENCY-deep response pipeline.
  - An out-of-range request returns ERR_DATA and increments `oob_cnt_o`.
- Simultaneous write and read in one cycle:
  - The read returns the pre-write contents (read-old), including when both target the same address.
  - The write commits.
  - `collide_cnt_o` increments.
- One event can increment several counters (e.g. an out-of-range, misaligned read increments both).
  - If the write and the read in one cycle are both out of range, `oob_cnt_o` increments by 2.
  - Likewise, `misalign_cnt_o` increments by up to 2 per cycle.
- Responses are strictly in request order. There is no reordering and no dropping while out of reset.
- `outstanding_o` = number of valid pipeline stages. Maximum value is RD_LATENCY.
- Counters saturate at 16'hFFFF and do not wrap.
- Store contents are not reset; they persist across `rst_ni`. The bench must write before reading.

## Timing
- Request at edge N → `ctx_mem_rd_resp_valid_o`=1 with data during the cycle after edge N+RD_LATENCY−1.
  - RD_LATENCY=1: data appears the cycle after the request.
- Back-to-back requests every cycle → back-to-back responses every cycle. Throughput is 1 per cycle.
- Responses are registered outputs. When not valid, `ctx_mem_rd_data_o` holds 0.
- Write-then-read of the same word:
  - Write at edge N, read request in cycle N+1 → returns the new data.
- Reset asserted, at any time:
  - All pipeline valids clear asynchronously; in-flight responses are lost.
  - Reset values: `ctx_mem_rd_resp_valid_o`=0, `ctx_mem_rd_data_o`=0, `outstanding_o`=0, all counters 0.
- First request is accepted on the first rising edge after `rst_ni` deasserts.

## Structure
- Package `ctx_mem_pkg`:
  - `ctx_addr_t` / `ctx_data_t` (logic [31:0]).
  - Counter width constant `CTX_CNT_W`=16.
  - Default `CTX_ERR_DATA`.
  - Function `ctx_in_range(addr, base, words)`.
- Sub-module `ctx_mem_rsp_pipe`:
  - Parameterised depth; carries a valid bit plus 32-bit data per stage; asynchronous reset on valids and data.
  - Provides the popcount of valid stages for `outstanding_o`.
- Top level holds the store array, range/alignment decode, counters and collision detect.

## Test plan
- Write 0x1234_5678 @ 0x40, then read @ 0x40 with RD_LATENCY=2 → valid 2 cycles later with 0x1234_5678; `outstanding_o` goes 1,1,0.
- Eight back-to-back reads @ 0x00..0x1C after writing values 0..7 → eight consecutive valid beats, data 0..7 in order, no gaps.
- Read @ BASE_ADDR+MEM_WORDS*4 → ERR_DATA returned, `oob_cnt_o`=1. Write to the same address → `oob_cnt_o`=2, store unchanged.
- Same-cycle write 0xAAAA_AAAA and read @ 0x10, with old value 0x5555_5555 → response 0x5555_5555, `collide_cnt_o`=1. A following read → 0xAAAA_AAAA.
- Read @ 0x13 → returns mem[4], `misalign_cnt_o`=1.
- Issue 2 reads, assert `rst_ni`=0 mid-flight → no response beats appear; all outputs 0. After release, a read of an earlier-written word returns the pre-reset contents.

Source files
------------

// File: rtl/ctx_mem_pkg.sv
// Shared types, constants and helpers for the context-memory responder.
package ctx_mem_pkg;

    localparam int unsigned CTX_ADDR_W = 32;
    localparam int unsigned CTX_DATA_W = 32;
    localparam int unsigned CTX_CNT_W  = 16;
    localparam int unsigned CTX_SUM_W  = CTX_CNT_W + 1;

    typedef logic [CTX_ADDR_W-1:0] ctx_addr_t;
    typedef logic [CTX_DATA_W-1:0] ctx_data_t;
    typedef logic [CTX_CNT_W-1:0]  ctx_cnt_t;

    localparam ctx_data_t CTX_ERR_DATA = 32'hDEAD_BEEF;

    // One response-pipeline stage: valid flag plus data word.
    typedef struct packed {
        logic      valid;
        ctx_data_t data;
    } ctx_beat_t;

    function automatic logic ctx_in_range(input ctx_addr_t addr,
                                          input ctx_addr_t base,
                                          input int unsigned words);
        ctx_addr_t off;
        off = addr - base;
        return off < ctx_addr_t'(words << 2);
    endfunction

    // Saturating add of a 0..3 increment; counters stick at all-ones.
    function automatic ctx_cnt_t ctx_sat_add(input ctx_cnt_t cnt, input logic [1:0] inc);
        logic [CTX_SUM_W-1:0] sum;
        sum = CTX_SUM_W'(cnt) + CTX_SUM_W'(inc);
        return sum[CTX_CNT_W] ? '1 : sum[CTX_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/ctx_mem_rsp_pipe.sv
// Fixed-depth read-response pipeline with a registered count of valid stages.
module ctx_mem_rsp_pipe
    import ctx_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  ctx_beat_t        in_i,
    output ctx_beat_t        out_o,
    output logic [CNT_W-1:0] count_o
);

    ctx_beat_t        stage_q [DEPTH];
    ctx_beat_t        stage_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Idle stages carry zero data so the output reads 0 when not valid.
    always_comb begin
        stage_d[0].valid = in_i.valid;
        stage_d[0].data  = in_i.valid ? in_i.data : '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        count_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_d = count_d + CNT_W'(stage_d[i].valid);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            count_q <= count_d;
        end
    end

    assign out_o   = stage_q[DEPTH-1];
    assign count_o = count_q;

endmodule

// File: rtl/ctx_mem_responder.sv
// Context-memory responder: word store, fixed-latency read responses and
// saturating protocol-anomaly counters.
module ctx_mem_responder
    import ctx_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter ctx_addr_t   BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned RD_LATENCY = 2,
    parameter ctx_data_t   ERR_DATA   = CTX_ERR_DATA
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ctx_mem_wr_en_i,
    input  logic [31:0]          ctx_mem_wr_addr_i,
    input  logic [31:0]          ctx_mem_wr_data_i,
    input  logic                 ctx_mem_rd_rq_valid_i,
    input  logic [31:0]          ctx_mem_rd_rq_addr_i,
    output logic                 ctx_mem_rd_resp_valid_o,
    output logic [31:0]          ctx_mem_rd_data_o,
    output logic [3:0]           outstanding_o,
    output logic [CTX_CNT_W-1:0] oob_cnt_o,
    output logic [CTX_CNT_W-1:0] misalign_cnt_o,
    output logic [CTX_CNT_W-1:0] collide_cnt_o
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned OUT_W = 4;

    ctx_data_t mem_q [MEM_WORDS];

    ctx_addr_t          wr_off;
    ctx_addr_t          rd_off;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic               wr_in_range;
    logic               rd_in_range;
    logic               wr_commit;
    logic [1:0]         oob_inc;
    logic [1:0]         mis_inc;
    logic [1:0]         col_inc;
    ctx_beat_t          rd_beat;
    ctx_beat_t          rsp_beat;

    ctx_cnt_t oob_cnt_q, oob_cnt_d;
    ctx_cnt_t misalign_cnt_q, misalign_cnt_d;
    ctx_cnt_t collide_cnt_q, collide_cnt_d;

    // Address decode: byte offset from base, aligned down to a word index.
    always_comb begin
        wr_off      = ctx_mem_wr_addr_i - BASE_ADDR;
        rd_off      = ctx_mem_rd_rq_addr_i - BASE_ADDR;
        wr_idx      = IDX_W'(wr_off >> 2);
        rd_idx      = IDX_W'(rd_off >> 2);
        wr_in_range = ctx_in_range(ctx_mem_wr_addr_i, BASE_ADDR, MEM_WORDS);
        rd_in_range = ctx_in_range(ctx_mem_rd_rq_addr_i, BASE_ADDR, MEM_WORDS);
        wr_commit   = ctx_mem_wr_en_i & wr_in_range;
    end

    // Store is deliberately unreset so contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (wr_commit) begin
            mem_q[wr_idx] <= ctx_mem_wr_data_i;
        end
    end

    // Sampling the array before the edge gives read-old on a same-cycle write.
    always_comb begin
        rd_beat.valid = ctx_mem_rd_rq_valid_i;
        rd_beat.data  = rd_in_range ? mem_q[rd_idx] : ERR_DATA;
    end

    ctx_mem_rsp_pipe #(
        .DEPTH (RD_LATENCY),
        .CNT_W (OUT_W)
    ) u_rsp_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .in_i    (rd_beat),
        .out_o   (rsp_beat),
        .count_o (outstanding_o)
    );

    // A write and a read in the same cycle can each bump a counter.
    always_comb begin
        oob_inc = 2'(ctx_mem_wr_en_i & ~wr_in_range)
                + 2'(ctx_mem_rd_rq_valid_i & ~rd_in_range);
        mis_inc = 2'(ctx_mem_wr_en_i & (|ctx_mem_wr_addr_i[1:0]))
                + 2'(ctx_mem_rd_rq_valid_i & (|ctx_mem_rd_rq_addr_i[1:0]));
        col_inc = 2'(ctx_mem_wr_en_i & ctx_mem_rd_rq_valid_i);

        oob_cnt_d      = ctx_sat_add(oob_cnt_q, oob_inc);
        misalign_cnt_d = ctx_sat_add(misalign_cnt_q, mis_inc);
        collide_cnt_d  = ctx_sat_add(collide_cnt_q, col_inc);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oob_cnt_q      <= '0;
            misalign_cnt_q <= '0;
            collide_cnt_q  <= '0;
        end else begin
            oob_cnt_q      <= oob_cnt_d;
            misalign_cnt_q <= misalign_cnt_d;
            collide_cnt_q  <= collide_cnt_d;
        end
    end

    assign ctx_mem_rd_resp_valid_o = rsp_beat.valid;
    assign ctx_mem_rd_data_o       = rsp_beat.data;
    assign oob_cnt_o               = oob_cnt_q;
    assign misalign_cnt_o          = misalign_cnt_q;
    assign collide_cnt_o           = collide_cnt_q;

endmodule

// File: tb/tb_ctx_mem_responder.sv
// Directed bench for ctx_mem_responder with a cycle-stamped response scoreboard.
module tb_ctx_mem_responder;

    localparam int          L         = 2;
    localparam int unsigned MEM_WORDS = 1024;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam logic [31:0] ERR       = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_v;
    logic [31:0] rd_addr;
    logic        rsp_v;
    logic [31:0] rsp_data;
    logic [3:0]  outst;
    logic [15:0] oob;
    logic [15:0] mis;
    logic [15:0] col;

    exp_t        sb [$];
    logic [31:0] model [MEM_WORDS];
    int          total;
    int          bad;
    int          cyc;

    ctx_mem_responder #(
        .MEM_WORDS  (MEM_WORDS),
        .BASE_ADDR  (BASE),
        .RD_LATENCY (L),
        .ERR_DATA   (ERR)
    ) dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .ctx_mem_wr_en_i         (wr_en),
        .ctx_mem_wr_addr_i       (wr_addr),
        .ctx_mem_wr_data_i       (wr_data),
        .ctx_mem_rd_rq_valid_i   (rd_v),
        .ctx_mem_rd_rq_addr_i    (rd_addr),
        .ctx_mem_rd_resp_valid_o (rsp_v),
        .ctx_mem_rd_data_o       (rsp_data),
        .outstanding_o           (outst),
        .oob_cnt_o               (oob),
        .misalign_cnt_o          (mis),
        .collide_cnt_o           (col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: every beat must match the oldest expectation on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_v === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_beat", 32'(rsp_v), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("beat_cycle", 32'(cyc), 32'(e.due));
                chk("beat_data", rsp_data, e.data);
            end
        end else begin
            chk("idle_data", rsp_data, 32'd0);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk("missing_beat", 32'(rsp_v), 32'd1);
            end
        end
    end

    // Drive one cycle of stimulus (called just after a falling edge).
    task automatic drive(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                         input logic re, input logic [31:0] ra);
        exp_t        e;
        int unsigned off;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_v    = re;
        rd_addr = ra;
        if (re) begin
            off    = ra - BASE;
            e.data = (off < MEM_WORDS * 4) ? model[off >> 2] : ERR;
            e.due  = cyc + L;
            sb.push_back(e);
        end
        if (we) begin
            off = wa - BASE;
            if (off < MEM_WORDS * 4) model[off >> 2] = wd;
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_v  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_v    = 1'b0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rsp_v), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_outst", 32'(outst), 32'd0);
        chk("rst_oob", 32'(oob), 32'd0);
        chk("rst_mis", 32'(mis), 32'd0);
        chk("rst_col", 32'(col), 32'd0);
        rst_n = 1'b1;

        // Basic write then read, latency and outstanding sequence.
        drive(1'b1, 32'h40, 32'h1234_5678, 1'b0, 32'd0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h40);
        chk("outst_a", 32'(outst), 32'd1);
        idle(1);
        chk("outst_b", 32'(outst), 32'd1);
        idle(1);
        chk("outst_c", 32'(outst), 32'd0);

        // Back-to-back burst.
        for (int i = 0; i < 8; i++) drive(1'b1, 32'(i * 4), 32'(i), 1'b0, 32'd0);
        for (int i = 0; i < 8; i++) drive(1'b0, 32'd0, 32'd0, 1'b1, 32'(i * 4));
        chk("outst_full", 32'(outst), 32'(L));
        idle(3);

        // Out-of-range read and write; word 0 must not be aliased.
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h1000);
        idle(2);
        chk("oob_rd", 32'(oob), 32'd1);
        drive(1'b1, 32'h1000, 32'h1111_1111, 1'b0, 32'd0);
        chk("oob_wr", 32'(oob), 32'd2);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h0);
        idle(2);

        // Same-cycle write/read collision, then read of new data.
        drive(1'b1, 32'h10, 32'h5555_5555, 1'b0, 32'd0);
        drive(1'b1, 32'h10, 32'hAAAA_AAAA, 1'b1, 32'h10);
        chk("collide", 32'(col), 32'd1);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h10);

        // Misaligned read aligns down.
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h13);
        chk("misalign", 32'(mis), 32'd1);
        idle(3);
        chk("cnt_oob", 32'(oob), 32'd2);
        chk("cnt_col", 32'(col), 32'd1);

        // Reset with reads in flight: responses are lost, state clears.
        rd_v    = 1'b1;
        rd_addr = 32'h0;
        @(posedge clk);
        #1 rd_addr = 32'h4;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rd_v  = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_valid", 32'(rsp_v), 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_outst", 32'(outst), 32'd0);
        chk("mid_rst_oob", 32'(oob), 32'd0);
        chk("mid_rst_mis", 32'(mis), 32'd0);
        chk("mid_rst_col", 32'(col), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Store contents persist across reset.
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h40);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h10);
        idle(3);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
